// File: rtl/nary_gate_sweep_checker.sv
// Exhaustive sweeper: drives all 2^N vectors to a gate under test and checks dut_out against the mode's golden function.
// Latency: done pulses exactly 2^N*HOLD cycles after the start that is accepted.
// Backpressure: none; start is only accepted in IDLE or DONE and is ignored mid-sweep.
module nary_gate_sweep_checker #(
    parameter int N    = 3,
    parameter int HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    output logic [N-1:0] stim,
    input  logic         dut_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err_vec,
    output logic         first_err_valid
);

    localparam int             CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0]  LAST     = CW'(HOLD - 1);
    localparam logic [N-1:0]   ALL_ONES = {N{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [1:0]    mode_q;
    logic [CW-1:0] hold_cnt;
    logic          expected;
    logic          mismatch;
    logic [N:0]    err_next;

    always_comb begin
        expected = 1'b0;
        case (mode_q)
            2'b00:   expected = ~&stim;
            2'b01:   expected = ~|stim;
            2'b10:   expected = &stim;
            default: expected = ^stim;
        endcase
        mismatch = (dut_out != expected);
        err_next = err_cnt + (N+1)'(mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            mode_q          <= 2'b00;
            stim            <= '0;
            hold_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q          <= mode;
                        err_cnt         <= '0;
                        pass            <= 1'b0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                        stim            <= '0;
                        hold_cnt        <= '0;
                        busy            <= 1'b1;
                        state           <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Sample on the last hold cycle so the gate has HOLD-1 cycles to settle.
                    if (hold_cnt == LAST) begin
                        err_cnt  <= err_next;
                        hold_cnt <= '0;
                        if (mismatch && !first_err_valid) begin
                            first_err_vec   <= stim;
                            first_err_valid <= 1'b1;
                        end
                        if (stim != ALL_ONES) begin
                            stim <= stim + N'(1);
                        end else begin
                            stim  <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                            state <= S_DONE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/nary_gate_sweep_checker.md
Name: nary_gate_sweep_checker

Overview:
Self-checking exhaustive stimulus engine for N-input combinational gate blocks. On start it walks all 2^N input vectors and holds each for a programmable number of cycles. It samples the DUT output at the end of each hold window, compares it against the golden function chosen by mode, and reports a mismatch count, the first failing vector and pass/fail. It is the synthesizable, parametrised successor to the free-running toggle benches used for the gate labs, and runs on-board or in simulation.

Parameters:
N, 3, number of gate inputs (1..16); the sweep covers 2^N vectors.
HOLD, 4, clock cycles each vector is driven (>=2); the DUT output is sampled on the last cycle.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse to begin a sweep; honoured only in IDLE or DONE
mode  input  2  golden function: 00 NAND, 01 NOR, 10 AND, 11 XOR
stim  output  N  registered input vector driven to the DUT
dut_out  input  1  DUT output under test
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  high after a sweep with zero mismatches; held until the next start
err_cnt  output  N+1  mismatch count of the last or current sweep
first_err_vec  output  N  vector of the first mismatch
first_err_valid  output  1  first_err_vec holds a valid vector

Behaviour:
- Reset (async, rst_n=0): state IDLE. stim=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0, hold counter=0.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1: latch mode, clear err_cnt/pass/first_err_*, stim=0, hold counter=0, go to RUN, busy=1 from the next cycle.
- RUN: hold counter increments each cycle from 0 to HOLD-1.
- RUN, counter==HOLD-1: sample dut_out. Expected value: NAND ~&stim, NOR ~|stim, AND &stim, XOR ^stim.
- Mismatch: err_cnt += 1. If first_err_valid=0, set first_err_vec=stim and first_err_valid=1.
- Same cycle: if stim != all-ones, stim += 1 and counter=0. Otherwise go to DONE.
- The DUT gets HOLD-1 settle cycles per vector. A sweep lasts exactly 2^N*HOLD cycles from entering RUN to entering DONE.
- Entering DONE: done=1 for exactly one cycle, busy=0, pass=(final err_cnt==0). The final sample's mismatch is included in pass.
- DONE: stim=0. err_cnt, pass and first_err_* are held until the next start.
- start while RUN is ignored; mode changes during RUN have no effect because mode is latched.
- err_cnt is N+1 bits, so it can reach 2^N without wrap. No saturation logic is needed.
- stim wraps never: the sweep stops at all-ones.
- rst_n asserted mid-sweep: immediate return to all reset values. No done pulse, no partial pass.

Test Plan:
- N=3, HOLD=4, mode=00, ideal NAND DUT, start pulse: stim walks 0..7 with 4 cycles each. done pulses exactly 32 cycles after entering RUN. Then err_cnt=0, pass=1, first_err_valid=0.
- Same setup, dut_out stuck at 0: err_cnt=7, pass=0, first_err_vec=3'b000, first_err_valid=1.
- mode=11 (XOR) with a NAND DUT: mismatches on vectors 000, 011, 101, 110, 111. Result err_cnt=5, first_err_vec=000, pass=0.
- Pulse start and toggle mode mid-sweep: no restart. Sweep still completes at cycle 32 with the originally latched mode.
- rst_n low during vector 5: all outputs go to 0 immediately and no done pulse follows. A new start afterwards runs a clean full sweep.
- N=4, HOLD=2, ideal AND DUT, mode=10: done after 32 cycles, err_cnt=0, pass=1. A second start clears the prior results and repeats identically.
